// File: rtl/edge_map_writer_pkg.sv
// Shared scan definitions: image geometry,
// scan direction codes and writer FSM states.
package edge_map_writer_pkg;

  localparam int N  = 150;
  localparam int AW = 15;
  localparam int NN = N * N;

  typedef enum logic [1:0] {
    MODE_LR  = 2'd0,
    MODE_UD  = 2'd1,
    MODE_TTL = 2'd2,
    MODE_TTR = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/scan_addr_gen.sv
// Incremental pixel address walker for the
// four scan orders; no multiplier on the path.
module scan_addr_gen
  import edge_map_writer_pkg::*;
(
  input  logic          clk,
  input  logic          resetIn,
  input  logic [1:0]    mode,
  input  logic          init,
  input  logic          step,
  output logic [AW-1:0] addr,
  output logic          line_end,
  output logic          last_pixel
);

  localparam logic [7:0]    NM1    = 8'(N - 1);
  localparam logic [8:0]    D_NM1  = 9'(N - 1);
  localparam logic [8:0]    D_NM2  = 9'(N - 2);
  localparam logic [8:0]    D_LAST = 9'(2 * N - 2);
  localparam logic [AW-1:0] A_N    = AW'(N);
  localparam logic [AW-1:0] A_NM1  = AW'(N - 1);
  localparam logic [AW-1:0] A_NP1  = AW'(N + 1);

  logic [7:0]    row_q, row_d;
  logic [7:0]    col_q, col_d;
  logic [8:0]    diag_q, diag_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] base_q, base_d;
  logic          diag_lo;
  logic [8:0]    dcol;

  assign addr    = addr_q;
  assign diag_lo = diag_q < D_NM1;
  assign dcol    = diag_q - D_NM2;

  // Line end and final pixel from the current position
  always_comb begin
    line_end   = 1'b0;
    last_pixel = 1'b0;
    unique case (mode)
      MODE_LR: begin
        line_end   = col_q == NM1;
        last_pixel = row_q == NM1 && col_q == NM1;
      end
      MODE_UD: begin
        line_end   = row_q == NM1;
        last_pixel = row_q == NM1 && col_q == NM1;
      end
      MODE_TTL: begin
        line_end   = row_q == 8'd0 || col_q == NM1;
        last_pixel = diag_q == D_LAST;
      end
      default: begin
        line_end   = row_q == 8'd0 || col_q == 8'd0;
        last_pixel = diag_q == D_LAST;
      end
    endcase
  end

  // Next position: restart on init, advance on step
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    diag_d = diag_q;
    addr_d = addr_q;
    base_d = base_q;
    if (init) begin
      row_d  = 8'd0;
      diag_d = 9'd0;
      col_d  = (mode == MODE_TTR) ? NM1 : 8'd0;
      addr_d = AW'(col_d);
      base_d = AW'(col_d);
    end else if (step) begin
      unique case (mode)
        MODE_LR: begin
          addr_d = addr_q + 1'b1;
          if (col_q == NM1) begin
            col_d = 8'd0;
            row_d = row_q + 8'd1;
          end else begin
            col_d = col_q + 8'd1;
          end
        end
        MODE_UD: begin
          if (row_q == NM1) begin
            row_d  = 8'd0;
            col_d  = col_q + 8'd1;
            addr_d = AW'(col_q) + 1'b1;
          end else begin
            row_d  = row_q + 8'd1;
            addr_d = addr_q + A_N;
          end
        end
        MODE_TTL: begin
          if (line_end) begin
            diag_d = diag_q + 9'd1;
            if (diag_lo) begin
              row_d  = diag_q[7:0] + 8'd1;
              col_d  = 8'd0;
              base_d = base_q + A_N;
            end else begin
              row_d  = NM1;
              col_d  = dcol[7:0];
              base_d = base_q + 1'b1;
            end
            addr_d = base_d;
          end else begin
            row_d  = row_q - 8'd1;
            col_d  = col_q + 8'd1;
            addr_d = addr_q - A_NM1;
          end
        end
        default: begin
          if (line_end) begin
            diag_d = diag_q + 9'd1;
            if (diag_lo) begin
              row_d  = diag_q[7:0] + 8'd1;
              col_d  = NM1;
              base_d = base_q + A_N;
            end else begin
              row_d  = NM1;
              col_d  = NM1 - dcol[7:0];
              base_d = base_q - 1'b1;
            end
            addr_d = base_d;
          end else begin
            row_d  = row_q - 8'd1;
            col_d  = col_q - 8'd1;
            addr_d = addr_q - A_NP1;
          end
        end
      endcase
    end
  end

  // Walker position registers
  always_ff @(posedge clk or posedge resetIn) begin
    if (resetIn) begin
      row_q  <= '0;
      col_q  <= '0;
      diag_q <= '0;
      addr_q <= '0;
      base_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      diag_q <= diag_d;
      addr_q <= addr_d;
      base_q <= base_d;
    end
  end

endmodule

// File: rtl/edge_map_writer.sv
// Edge-map write-back: pass FSM, registered
// RAM write port and scan-line consistency check.
module edge_map_writer
  import edge_map_writer_pkg::*;
(
  input  logic          clk,
  input  logic          resetIn,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_edge,
  input  logic          in_last,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [3:0]    wr_mask,
  output logic [3:0]    wr_data,
  output logic          busy,
  output logic          done,
  output logic          line_err
);

  state_e        state_q;
  logic [1:0]    mode_q;
  logic          ready_q;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [3:0]    wr_mask_q;
  logic [3:0]    wr_data_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic          accept;
  logic          gen_init;
  logic [1:0]    gen_mode;
  logic [AW-1:0] gen_addr;
  logic          gen_end;
  logic          gen_last;

  assign accept   = in_valid && ready_q;
  assign gen_init = (state_q == S_IDLE) && start;
  assign gen_mode = (state_q == S_IDLE) ? mode : mode_q;

  assign in_ready = ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_mask  = wr_mask_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign line_err = err_q;

  scan_addr_gen u_gen (
    .clk        (clk),
    .resetIn    (resetIn),
    .mode       (gen_mode),
    .init       (gen_init),
    .step       (accept),
    .addr       (gen_addr),
    .line_end   (gen_end),
    .last_pixel (gen_last)
  );

  // Pass FSM with registered write port and status
  always_ff @(posedge clk or posedge resetIn) begin
    if (resetIn) begin
      state_q   <= S_IDLE;
      mode_q    <= 2'd0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_mask_q <= 4'd0;
      wr_data_q <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q  <= mode;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= gen_addr;
            wr_mask_q <= 4'b0001 << mode_q;
            wr_data_q <= {4{in_edge}};
            if (in_last != gen_end) begin
              err_q <= 1'b1;
            end
            if (gen_last) begin
              ready_q <= 1'b0;
              state_q <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_map_writer.sv
// Scoreboard bench for edge_map_writer:
// direction passes, line check, reset mid-pass.
module tb_edge_map_writer;
  import edge_map_writer_pkg::*;

  typedef struct {
    int         addr;
    logic [3:0] mask;
    logic       ebit;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetIn = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_edge = 1'b0;
  logic          in_last = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_mask;
  logic [3:0]    wr_data;
  logic          busy;
  logic          done;
  logic          line_err;

  int   checks = 0;
  int   errors = 0;
  int   exp_addr [NN];
  bit   exp_last [NN];
  exp_t sb [$];
  exp_t mon_e;
  bit   mon_en = 1'b0;
  bit   acc_prev = 1'b0;

  edge_map_writer dut (
    .clk      (clk),
    .resetIn  (resetIn),
    .start    (start),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_edge  (in_edge),
    .in_last  (in_last),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_mask  (wr_mask),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .line_err (line_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (wr_en !== acc_prev) begin
        errors++;
        if (errors < 30)
          $display("FAIL wr_en got %b exp %b t=%0t",
                   wr_en, acc_prev, $time);
      end
      if (wr_en === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          if (errors < 30)
            $display("FAIL sb_empty got write addr %0d", wr_addr);
        end else begin
          mon_e = sb.pop_front();
          if (wr_addr !== AW'(mon_e.addr) ||
              wr_mask !== mon_e.mask ||
              wr_data !== {4{mon_e.ebit}}) begin
            errors++;
            if (errors < 30)
              $display("FAIL write got a=%0d m=%b d=%b exp a=%0d m=%b d=%b",
                       wr_addr, wr_mask, wr_data, mon_e.addr,
                       mon_e.mask, {4{mon_e.ebit}});
          end
        end
      end
      acc_prev = (in_valid === 1'b1) && (in_ready === 1'b1);
    end
  end

  task automatic build(input int m);
    int k = 0;
    int r, c;
    bit endl;
    if (m == 0) begin
      for (int rr = 0; rr < N; rr++)
        for (int cc = 0; cc < N; cc++) begin
          exp_addr[k] = rr * N + cc;
          exp_last[k] = (cc == N - 1);
          k++;
        end
    end else if (m == 1) begin
      for (int cc = 0; cc < N; cc++)
        for (int rr = 0; rr < N; rr++) begin
          exp_addr[k] = rr * N + cc;
          exp_last[k] = (rr == N - 1);
          k++;
        end
    end else begin
      for (int d = 0; d < 2 * N - 1; d++) begin
        r = (d < N - 1) ? d : N - 1;
        c = (m == 2) ? d - r : N - 1 - (d - r);
        endl = 1'b0;
        while (!endl) begin
          exp_addr[k] = r * N + c;
          endl = (r == 0) || ((m == 2) ? (c == N - 1) : (c == 0));
          exp_last[k] = endl;
          k++;
          r--;
          c = (m == 2) ? c + 1 : c - 1;
        end
      end
    end
  endtask

  task automatic start_pass(input int m);
    @(posedge clk); #1;
    start = 1'b1;
    mode = 2'(m);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || line_err !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start got busy=%b err=%b rdy=%b exp 1 0 1",
               busy, line_err, in_ready);
    end
  endtask

  task automatic drive(input int m, input int gap_until,
                       input int bad_idx, input int start_idx,
                       input int stop_at);
    int i = 0;
    int stall = 0;
    bit v;
    while (i < stop_at && stall < 50) begin
      @(posedge clk); #1;
      v = (i >= gap_until) || ($urandom_range(0, 2) != 0);
      in_valid = v;
      in_edge = 1'($urandom);
      in_last = exp_last[i] ^ (i == bad_idx);
      start = (i == start_idx);
      mode = start ? 2'(m ^ 1) : 2'(m);
      @(negedge clk);
      if (v && in_ready === 1'b1) begin
        sb.push_back('{exp_addr[i], 4'(1 << m), in_edge});
        i++;
        stall = 0;
      end else if (v) begin
        stall++;
      end
    end
    checks++;
    if (stall >= 50) begin
      errors++;
      $display("FAIL stall got %0d beats exp %0d", i, stop_at);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    start = 1'b0;
    mode = 2'(m);
  endtask

  task automatic finish_pass(input bit exp_err);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL flush got done=%b busy=%b exp 0 1", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 ||
        line_err !== exp_err) begin
      errors++;
      $display("FAIL done got done=%b busy=%b rdy=%b err=%b exp 1 0 0 %b",
               done, busy, in_ready, line_err, exp_err);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || line_err !== exp_err) begin
      errors++;
      $display("FAIL after_done got done=%b err=%b exp 0 %b",
               done, line_err, exp_err);
    end
  endtask

  task automatic test_reset();
    #2 resetIn = 1'b1;
    #2;
    checks++;
    if ({in_ready, wr_en, wr_addr, wr_mask, busy, done, line_err} !== '0) begin
      errors++;
      $display("FAIL reset got rdy=%b we=%b a=%0d m=%b b=%b d=%b e=%b exp 0",
               in_ready, wr_en, wr_addr, wr_mask, busy, done, line_err);
    end
    @(negedge clk);
    resetIn = 1'b0;
    #1 mon_en = 1'b1;
  endtask

  task automatic test_lr_line_err();
    build(0);
    start_pass(0);
    drive(0, 200, 10, -1, NN);
    finish_pass(1'b1);
  endtask

  task automatic test_dir(input int m);
    build(m);
    start_pass(m);
    drive(m, 0, -1, -1, NN);
    finish_pass(1'b0);
  endtask

  task automatic test_reset_mid();
    build(0);
    start_pass(0);
    drive(0, 0, -1, -1, 5000);
    mon_en = 1'b0;
    #2 resetIn = 1'b1;
    #1;
    checks++;
    if ({in_ready, wr_en, wr_addr, wr_mask, busy, done, line_err} !== '0) begin
      errors++;
      $display("FAIL mid_reset got rdy=%b we=%b a=%0d m=%b b=%b exp 0",
               in_ready, wr_en, wr_addr, wr_mask, busy);
    end
    sb.delete();
    acc_prev = 1'b0;
    @(negedge clk);
    resetIn = 1'b0;
    #1 mon_en = 1'b1;
  endtask

  task automatic test_ud_after_reset();
    build(1);
    start_pass(1);
    drive(1, 0, -1, 3000, NN);
    finish_pass(1'b0);
  endtask

  initial begin
    test_reset();
    test_lr_line_err();
    test_dir(2);
    test_dir(3);
    test_reset_mid();
    test_ud_after_reset();
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_left got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
